// File: rtl/bcd_pkg.sv
// Shared widths, digit limits and output-FSM encoding for the serial BCD collector.
package bcd_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned BIT_CNT_W = 2;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_deser.sv
// Serial-in, LSB-first assembly of one 4-bit digit; flags completion and non-BCD values.
module bcd_digit_deser
    import bcd_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               din_i,
    input  logic               din_valid_i,
    output logic [DIGIT_W-1:0] digit_c_o,
    output logic               digit_done_c_o,
    output logic               digit_bad_c_o
);

    logic [DIGIT_W-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 cap;

    // The digit view includes the bit arriving on this edge so the last-bit check sees all 4 bits.
    always_comb begin
        cap                = din_valid_i && !clr_i;
        shift_d            = shift_q;
        shift_d[bit_cnt_q] = din_i;
        bit_cnt_d          = bit_cnt_q;
        if (clr_i) begin
            bit_cnt_d = '0;
        end else if (cap) begin
            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            if (cap) begin
                shift_q <= shift_d;
            end
        end
    end

    assign digit_c_o      = shift_d;
    assign digit_done_c_o = cap && (bit_cnt_q == BIT_CNT_W'(DIGIT_W - 1));
    assign digit_bad_c_o  = digit_done_c_o && !is_bcd(shift_d);

endmodule

// File: rtl/bcd_serial_collector.sv
// Collects serial BCD digits into NUM_DIGITS-digit words behind a one-entry valid/ready register.
module bcd_serial_collector
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Clr,
    input  logic                          Din,
    input  logic                          Din_valid,
    output logic [DIGIT_W*NUM_DIGITS-1:0] Dout,
    output logic                          Dout_valid,
    input  logic                          Dout_ready,
    output logic                          Dout_err,
    output logic                          Overrun
);

    localparam int unsigned WORD_W    = DIGIT_W * NUM_DIGITS;
    localparam int unsigned DIG_CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIGIT_W-1:0]   digit;
    logic                 digit_done;
    logic                 digit_bad;

    logic [DIG_CNT_W-1:0] dig_cnt_q, dig_cnt_d;
    logic [WORD_W-1:0]    acc_q, acc_d;
    logic                 err_acc_q, err_acc_d;
    logic                 word_done;
    logic                 word_err;

    out_state_e           state_q, state_d;
    logic [WORD_W-1:0]    dout_q, dout_d;
    logic                 dout_err_q, dout_err_d;
    logic                 overrun_q, overrun_d;
    logic                 load;

    bcd_digit_deser u_deser (
        .clk_i          (Clk),
        .rst_i          (Rst),
        .clr_i          (Clr),
        .din_i          (Din),
        .din_valid_i    (Din_valid),
        .digit_c_o      (digit),
        .digit_done_c_o (digit_done),
        .digit_bad_c_o  (digit_bad)
    );

    // Word assembly: place each finished digit, accumulate the error flag, detect word end.
    always_comb begin
        dig_cnt_d = dig_cnt_q;
        acc_d     = acc_q;
        err_acc_d = err_acc_q;
        word_done = 1'b0;
        word_err  = err_acc_q | digit_bad;
        if (Clr) begin
            dig_cnt_d = '0;
            err_acc_d = 1'b0;
        end else if (digit_done) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (dig_cnt_q == DIG_CNT_W'(i)) begin
                    acc_d[i*DIGIT_W +: DIGIT_W] = digit;
                end
            end
            if (dig_cnt_q == DIG_CNT_W'(NUM_DIGITS - 1)) begin
                word_done = 1'b1;
                dig_cnt_d = '0;
                err_acc_d = 1'b0;
            end else begin
                dig_cnt_d = DIG_CNT_W'(dig_cnt_q + 1'b1);
                err_acc_d = word_err;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (word_done) state_d = ST_FULL;
            ST_FULL:  if (Dout_ready && !word_done) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // A finished word loads only if the register is free or being drained on this same edge.
    always_comb begin
        load       = word_done && ((state_q == ST_EMPTY) || Dout_ready);
        dout_d     = dout_q;
        dout_err_d = dout_err_q;
        overrun_d  = word_done && (state_q == ST_FULL) && !Dout_ready;
        if (load) begin
            dout_d     = acc_d;
            dout_err_d = word_err;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dig_cnt_q  <= '0;
            acc_q      <= '0;
            err_acc_q  <= 1'b0;
            dout_q     <= '0;
            dout_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dig_cnt_q  <= dig_cnt_d;
            acc_q      <= acc_d;
            err_acc_q  <= err_acc_d;
            dout_q     <= dout_d;
            dout_err_q <= dout_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign Dout       = dout_q;
    assign Dout_err   = dout_err_q;
    assign Overrun    = overrun_q;
    assign Dout_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Directed and randomized checks of bcd_serial_collector with NUM_DIGITS=2.
module tb_bcd_serial_collector;

    logic       Clk;
    logic       Rst;
    logic       Clr;
    logic       Din;
    logic       Din_valid;
    logic [7:0] Dout;
    logic       Dout_valid;
    logic       Dout_ready;
    logic       Dout_err;
    logic       Overrun;

    int errors = 0;
    int checks = 0;

    bcd_serial_collector #(.NUM_DIGITS(2)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Clr        (Clr),
        .Din        (Din),
        .Din_valid  (Din_valid),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready),
        .Dout_err   (Dout_err),
        .Overrun    (Overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        Din       = b;
        Din_valid = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic idle();
        Din_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (Dout !== 8'h00)    begin errors++; $display("FAIL reset_dout got=%h exp=00", Dout); end
        checks++; if (Dout_valid !== 0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", Dout_valid); end
        checks++; if (Dout_err !== 0)    begin errors++; $display("FAIL reset_err got=%b exp=0", Dout_err); end
        checks++; if (Overrun !== 0)     begin errors++; $display("FAIL reset_ovr got=%b exp=0", Overrun); end
        tick();
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [6:0] first7;
        first7 = 7'b1110101;
        Dout_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(first7[i]);
        checks++; if (Dout_valid !== 0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", Dout_valid); end
        send_bit(1'b0);
        checks++; if (Dout_valid !== 1) begin errors++; $display("FAIL basic_valid got=%b exp=1", Dout_valid); end
        checks++; if (Dout !== 8'h75)   begin errors++; $display("FAIL basic_dout got=%h exp=75", Dout); end
        checks++; if (Dout_err !== 0)   begin errors++; $display("FAIL basic_err got=%b exp=0", Dout_err); end
        idle();
        checks++; if (Dout_valid !== 0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", Dout_valid); end
    endtask

    task automatic test_err_flag();
        Dout_ready = 1'b1;
        send_word(8'hC3);
        checks++; if (Dout !== 8'hC3) begin errors++; $display("FAIL err_dout got=%h exp=c3", Dout); end
        checks++; if (Dout_err !== 1) begin errors++; $display("FAIL err_flag got=%b exp=1", Dout_err); end
        send_word(8'h00);
        checks++; if (Dout !== 8'h00) begin errors++; $display("FAIL err_next_dout got=%h exp=00", Dout); end
        checks++; if (Dout_err !== 0) begin errors++; $display("FAIL err_not_sticky got=%b exp=0", Dout_err); end
        checks++; if (Dout_valid !== 1) begin errors++; $display("FAIL err_next_valid got=%b exp=1", Dout_valid); end
        idle();
    endtask

    task automatic test_overrun();
        logic [7:0] w;
        w = 8'h34;
        Dout_ready = 1'b0;
        send_word(8'h12);
        checks++; if (Dout !== 8'h12) begin errors++; $display("FAIL ovr_first_dout got=%h exp=12", Dout); end
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        checks++; if (Overrun !== 0) begin errors++; $display("FAIL ovr_early got=%b exp=0", Overrun); end
        send_bit(w[7]);
        checks++; if (Overrun !== 1) begin errors++; $display("FAIL ovr_pulse got=%b exp=1", Overrun); end
        checks++; if (Dout !== 8'h12) begin errors++; $display("FAIL ovr_hold_dout got=%h exp=12", Dout); end
        idle();
        checks++; if (Overrun !== 0) begin errors++; $display("FAIL ovr_one_cycle got=%b exp=0", Overrun); end
        checks++; if (Dout_valid !== 1) begin errors++; $display("FAIL ovr_still_valid got=%b exp=1", Dout_valid); end
        Dout_ready = 1'b1;
        tick();
        checks++; if (Dout_valid !== 0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", Dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        w = 8'h34;
        Dout_ready = 1'b0;
        send_word(8'h12);
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        Dout_ready = 1'b1;
        send_bit(w[7]);
        checks++; if (Dout !== 8'h34)   begin errors++; $display("FAIL b2b_dout got=%h exp=34", Dout); end
        checks++; if (Dout_valid !== 1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", Dout_valid); end
        checks++; if (Overrun !== 0)    begin errors++; $display("FAIL b2b_ovr got=%b exp=0", Overrun); end
        idle();
        checks++; if (Dout_valid !== 0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", Dout_valid); end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        w = 8'hA7;
        Dout_ready = 1'b0;
        send_word(8'h56);
        for (int i = 0; i < 5; i++) send_bit(w[i]);
        Din_valid = 1'b0;
        #3 Rst = 1'b1;
        #1;
        checks++; if (Dout !== 8'h00)   begin errors++; $display("FAIL arst_dout got=%h exp=00", Dout); end
        checks++; if (Dout_valid !== 0) begin errors++; $display("FAIL arst_valid got=%b exp=0", Dout_valid); end
        checks++; if (Dout_err !== 0)   begin errors++; $display("FAIL arst_err got=%b exp=0", Dout_err); end
        #2 Rst = 1'b0;
        tick();
        Dout_ready = 1'b1;
        send_word(8'h91);
        checks++; if (Dout !== 8'h91)   begin errors++; $display("FAIL arst_next_dout got=%h exp=91", Dout); end
        checks++; if (Dout_valid !== 1) begin errors++; $display("FAIL arst_next_valid got=%b exp=1", Dout_valid); end
        idle();
    endtask

    task automatic test_clr_gaps();
        logic [7:0] w;
        w = 8'h47;
        Dout_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        Clr = 1'b1;
        Din = 1'b1;
        Din_valid = 1'b1;
        tick();
        Clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                Din = 1'($urandom_range(0, 1));
                idle();
            end
            if (i == 7) begin
                checks++; if (Dout_valid !== 0) begin errors++; $display("FAIL clr_early_valid got=%b exp=0", Dout_valid); end
            end
            send_bit(w[i]);
        end
        checks++; if (Dout !== 8'h47)   begin errors++; $display("FAIL clr_dout got=%h exp=47", Dout); end
        checks++; if (Dout_err !== 0)   begin errors++; $display("FAIL clr_err got=%b exp=0", Dout_err); end
        checks++; if (Dout_valid !== 1) begin errors++; $display("FAIL clr_valid got=%b exp=1", Dout_valid); end
        idle();
    endtask

    task automatic test_random();
        logic [7:0] m_word, m_dout;
        logic       m_valid, m_err, m_ovr, werr, dv, d, rdy;
        int         m_cnt;
        Din_valid = 1'b0;
        Rst = 1'b1;
        #2 Rst = 1'b0;
        tick();
        m_word = '0; m_dout = '0; m_valid = 0; m_err = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 16000; cyc++) begin
            dv  = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) != 0);
            Din = d; Din_valid = dv; Dout_ready = rdy;
            tick();
            m_ovr = 1'b0;
            if (dv && m_cnt == 7) begin
                m_word[7] = d;
                m_cnt = 0;
                werr = (m_word[3:0] > 4'd9) || (m_word[7:4] > 4'd9);
                if (!m_valid || rdy) begin
                    m_dout = m_word; m_err = werr; m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                if (dv) begin
                    m_word[m_cnt] = d;
                    m_cnt++;
                end
                if (m_valid && rdy) m_valid = 1'b0;
            end
            checks++; if (Dout_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, Dout_valid, m_valid); end
            checks++; if (Overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr cyc=%0d got=%b exp=%b", cyc, Overrun, m_ovr); end
            if (m_valid) begin
                checks++; if (Dout !== m_dout) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", cyc, Dout, m_dout); end
                checks++; if (Dout_err !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, Dout_err, m_err); end
            end
        end
        Din_valid = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Clr = 1'b0; Din = 1'b0; Din_valid = 1'b0; Dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_err_flag();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_clr_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
